conv2d_stream: RTL and testbench

//  Streaming KxK 2-D convolution over an IMG_W x IMG_H raster of signed Q-format pixels; successor to conv_top.

---
 rtl/conv_pkg.sv | 63 ++++++
 rtl/conv_line_buffer.sv | 43 ++++
 rtl/conv2d_stream.sv | 217 +++++++++++++++++++++
 tb/tb_conv2d_stream.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv2d_stream block.
//   conv_state_t : frame FSM states (IDLE, RUN, DRAIN)
//   clog2        : ceiling log2, never less than 1 (safe for port widths)
//   acc_w        : accumulator width for a KxK tree of DWxDW signed products
//   round_sat    : round-half-up by 2^q, then saturate to a signed dw-bit range
// The rounding helper works on a fixed maximum width so one function serves
// every parameterisation; callers sign-extend into it and slice the result.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } conv_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int acc_w(input int dw, input int k);
    return 2 * dw + clog2(k * k);
  endfunction

  localparam int DW_MAX    = 64;
  localparam int K_MAX     = 7;
  // One spare bit guarantees a non-empty sign extension from any legal ACC_W.
  localparam int ACC_W_MAX = acc_w(DW_MAX, K_MAX) + 1;

  typedef struct packed {
    logic [DW_MAX-1:0] res;
    logic              sat;
  } rs_t;

  function automatic rs_t round_sat(input logic signed [ACC_W_MAX-1:0] acc,
                                    input int q, input int dw);
    rs_t                      o;
    logic signed [ACC_W_MAX:0] ext;
    logic signed [ACC_W_MAX:0] one;
    logic signed [ACC_W_MAX:0] hi;
    logic signed [ACC_W_MAX:0] lo;
    one    = '0;
    one[0] = 1'b1;
    ext    = {acc[ACC_W_MAX-1], acc};
    if (q > 0) ext = ext + (one <<< (q - 1));
    ext    = ext >>> q;
    hi     = (one <<< (dw - 1)) - one;
    lo     = -(one <<< (dw - 1));
    o.sat  = 1'b0;
    o.res  = ext[DW_MAX-1:0];
    if (ext > hi) begin
      o.res = hi[DW_MAX-1:0];
      o.sat = 1'b1;
    end else if (ext < lo) begin
      o.res = lo[DW_MAX-1:0];
      o.sat = 1'b1;
    end
    return o;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row line buffer for the streaming convolution.
// Each row is a DEPTH-entry RAM addressed by the current column. On en_i the
// incoming pixel is written into row 0 while the old contents of row g cascade
// into row g+1, so tap g always holds the pixel g+1 rows above the input.
// Ports:
//   clk    : clock
//   en_i   : shift enable (one accepted/generated pixel)
//   addr_i : current column
//   din_i  : incoming pixel
//   taps_o : ROWS column taps, tap g in bits [g*DW +: DW]
// Contents are not reset; the caller gates their use by its row/col counters.
module conv_line_buffer #(
  parameter int DEPTH = 100,
  parameter int DW    = 32,
  parameter int ROWS  = 2,
  parameter int AW    = 7
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [DW-1:0]      din_i,
  output logic [ROWS*DW-1:0] taps_o
);

  for (genvar g = 0; g < ROWS; g++) begin : g_row
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] row_in;

    if (g == 0) begin : g_first
      assign row_in = din_i;
    end else begin : g_next
      assign row_in = taps_o[(g-1)*DW +: DW];
    end

    // Read-before-write: the tap shows last row's pixel in this column.
    assign taps_o[g*DW +: DW] = mem_q[addr_i];

    always_ff @(posedge clk) begin
      if (en_i) mem_q[addr_i] <= row_in;
    end
  end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK 2-D convolution over an IMG_W x IMG_H raster of signed
// Q-format pixels, one frame per start pulse, with run-time coefficients.
// Optional feature: define CONV_PAD_SAME_EN for "same" mode (zero border of
// (K-1)/2 generated internally, IMG_W*IMG_H results); otherwise "valid" mode.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a frame (IDLE only)
//   coef_we/addr/data : coefficient write, index r*K+c (IDLE only)
//   s_valid/ready/data: input pixel stream, raster order
//   m_valid/ready/data: result stream, raster order
//   busy_o            : frame in progress (RUN/DRAIN)
//   done_o            : one-cycle pulse at frame end
//   sat_o             : sticky, a result of this frame saturated
//   state_o           : current FSM state (conv_state_t encoding)
// Handshake: a transfer happens on a clock edge where valid && ready are both
// high; m_valid/m_data stay stable while m_valid && !m_ready. The whole
// pipeline (window, multiply, adder tree, round/sat) advances only when the
// output register can move (pipe_adv).
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int IMG_W      = 100,
  parameter int IMG_H      = 100,
  parameter int K          = 3,
  parameter int DATA_WIDTH = 32,
  parameter int Q          = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    coef_we,
  input  logic [clog2(K*K)-1:0]   coef_addr,
  input  logic [DATA_WIDTH-1:0]   coef_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    sat_o,
  output logic [1:0]              state_o
);

`ifdef CONV_PAD_SAME_EN
  localparam int P = (K - 1) / 2;
`else
  localparam int P = 0;
`endif
  localparam int DW    = DATA_WIDTH;
  localparam int KK    = K * K;
  localparam int W_T   = IMG_W + 2 * P;
  localparam int H_T   = IMG_H + 2 * P;
  localparam int CW    = clog2(W_T);
  localparam int RW    = clog2(H_T);
  localparam int ACC_W = acc_w(DW, K);

  conv_state_t             state_q;
  logic [CW-1:0]           col_q;
  logic [RW-1:0]           row_q;
  logic                    done_q, sat_q;
  logic signed [DW-1:0]    coef_q [KK];
  logic signed [DW-1:0]    win_q [K][K];
  logic signed [DW-1:0]    col_vec [K];
  logic signed [2*DW-1:0]  prod_d [KK];
  logic signed [2*DW-1:0]  prod_q [KK];
  logic signed [ACC_W-1:0] sum_d, acc_q;
  logic                    win_v_q, prod_v_q, sum_v_q, m_valid_q;
  logic [DW-1:0]           m_data_q;
  logic [(K-1)*DW-1:0]     taps;
  logic [DW-1:0]           pix;
  logic                    run, pipe_adv, step, win_cplt;
  rs_t                     rs;
  logic                    unused_rs;

  assign run      = (state_q == RUN);
  assign pipe_adv = !m_valid_q || m_ready;

`ifdef CONV_PAD_SAME_EN
  logic is_pad;
  // Border positions of the padded raster feed zeros and consume no input.
  assign is_pad  = (int'(row_q) < P) || (int'(row_q) >= P + IMG_H) ||
                   (int'(col_q) < P) || (int'(col_q) >= P + IMG_W);
  assign pix     = is_pad ? '0 : s_data;
  assign s_ready = run && pipe_adv && !is_pad;
  assign step    = run && pipe_adv && (is_pad || s_valid);
`else
  assign pix     = s_data;
  assign s_ready = run && pipe_adv;
  assign step    = s_valid && s_ready;
`endif

  assign win_cplt = (int'(row_q) >= K - 1) && (int'(col_q) >= K - 1);

  conv_line_buffer #(.DEPTH(W_T), .DW(DW), .ROWS(K-1), .AW(CW)) u_lb (
    .clk    (clk),
    .en_i   (step),
    .addr_i (col_q),
    .din_i  (pix),
    .taps_o (taps)
  );

  // Window row 0 is the oldest line; the new pixel enters the bottom row.
  always_comb begin
    col_vec[K-1] = pix;
    for (int j = 0; j < K - 1; j++) col_vec[K-2-j] = taps[j*DW +: DW];
  end

  always_comb begin
    logic signed [2*DW-1:0] a, b;
    a = '0;
    b = '0;
    for (int i = 0; i < KK; i++) begin
      a = {{DW{win_q[i/K][i%K][DW-1]}}, win_q[i/K][i%K]};
      b = {{DW{coef_q[i][DW-1]}}, coef_q[i]};
      prod_d[i] = a * b;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < KK; i++)
      sum_d = sum_d + {{(ACC_W-2*DW){prod_q[i][2*DW-1]}}, prod_q[i]};
  end

  assign rs        = round_sat({{(ACC_W_MAX-ACC_W){acc_q[ACC_W-1]}}, acc_q}, Q, DW);
  assign unused_rs = ^rs.res;

  // Datapath registers; stale contents are harmless because every stage is
  // qualified by its valid bit.
  always_ff @(posedge clk) begin
    if (step) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-1] <= col_vec[r];
      end
    end
    if (pipe_adv) begin
      for (int i = 0; i < KK; i++) prod_q[i] <= prod_d[i];
      acc_q <= sum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_v_q   <= 1'b0;
      prod_v_q  <= 1'b0;
      sum_v_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (pipe_adv) begin
      win_v_q   <= step && win_cplt;
      prod_v_q  <= win_v_q;
      sum_v_q   <= prod_v_q;
      m_valid_q <= sum_v_q;
      if (sum_v_q) m_data_q <= rs.res[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      for (int i = 0; i < KK; i++) coef_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (pipe_adv && sum_v_q && rs.sat) sat_q <= 1'b1;
      case (state_q)
        IDLE: begin
          // A write in the same cycle as start lands before the frame runs.
          if (coef_we && (int'(coef_addr) < KK)) coef_q[coef_addr] <= coef_data;
          if (start) begin
            state_q <= RUN;
            row_q   <= '0;
            col_q   <= '0;
            sat_q   <= 1'b0;
          end
        end
        RUN: begin
          if (step) begin
            if (col_q == CW'(W_T - 1)) begin
              col_q <= '0;
              if (row_q == RW'(H_T - 1)) begin
                row_q   <= '0;
                state_q <= DRAIN;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Leave once the final result is being taken and nothing follows it.
          if (pipe_adv && !win_v_q && !prod_v_q && !sum_v_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign sat_o   = sat_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream at 8x8, K=3, 32-bit, Q=10.
// Define CONV_PAD_SAME_EN for both bench and RTL to exercise "same" mode.
module tb_conv2d_stream;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int K  = 3;
  localparam int DW = 32;
  localparam int Q  = 10;
`ifdef CONV_PAD_SAME_EN
  localparam int NRES = 64;
`else
  localparam int NRES = 36;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic          coef_we;
  logic [3:0]    coef_addr;
  logic [DW-1:0] coef_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          busy_o;
  logic          done_o;
  logic          sat_o;
  logic [1:0]    state_o;

  conv2d_stream #(.IMG_W(W), .IMG_H(H), .K(K), .DATA_WIDTH(DW), .Q(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .sat_o     (sat_o),
    .state_o   (state_o)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] coef_v [9];
  logic [DW-1:0] pix_v [64];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic load_coefs();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 4'(i);
      coef_data = coef_v[i];
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic set_coefs(input logic [DW-1:0] centre, input logic [DW-1:0] others);
    for (int i = 0; i < 9; i++) coef_v[i] = (i == 4) ? centre : others;
  endtask

  task automatic fill_pix(input logic [DW-1:0] v);
    for (int i = 0; i < 64; i++) pix_v[i] = v;
  endtask

  task automatic push_const(input logic [DW-1:0] v);
    for (int i = 0; i < NRES; i++) exp_q.push_back(v);
  endtask

  // Identity kernel: the result is the window centre pixel.
  task automatic push_identity();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
`ifdef CONV_PAD_SAME_EN
        exp_q.push_back(pix_v[r*W+c]);
`else
        if (r >= 1 && r <= H - 2 && c >= 1 && c <= W - 2) exp_q.push_back(pix_v[r*W+c]);
`endif
      end
  endtask

  // All-ones kernel over constant 2048 (2.0): result = cells_in_image * 2048.
  task automatic push_box2048();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
`ifdef CONV_PAD_SAME_EN
        int nr, nc;
        nr = (r == 0 || r == H - 1) ? 2 : 3;
        nc = (c == 0 || c == W - 1) ? 2 : 3;
        exp_q.push_back(DW'(nr * nc * 2048));
`else
        if (r >= 1 && r <= H - 2 && c >= 1 && c <= W - 2) exp_q.push_back(32'd18432);
`endif
      end
  endtask

  // Driver + scoreboard for one frame. Sampling happens 1 time unit after the
  // falling edge; a handshake seen here completes at the next rising edge.
  task automatic run_frame(input string name, input int gap_pct, input int rdy_pct,
                           input int abort_at, input int n_exp);
    int            idx, n_out, done_seen, cyc;
    logic          hold;
    logic [DW-1:0] held;
    idx = 0; n_out = 0; done_seen = 0; cyc = 0; hold = 1'b0; held = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done_seen == 0 && cyc < 4000) begin
      if (idx < 64 && $urandom_range(99) >= 32'(gap_pct)) begin
        s_valid = 1'b1;
        s_data  = pix_v[idx];
      end else begin
        s_valid = 1'b0;
        s_data  = $urandom;
      end
      m_ready = ($urandom_range(99) < 32'(rdy_pct));
      #1;
      if (hold) begin
        check({name, "_stall_valid"}, DW'(m_valid), 32'd1);
        check({name, "_stall_data"}, m_data, held);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check({name, "_extra_result"}, DW'(n_out + 1), DW'(n_exp));
        else check({name, "_data"}, m_data, exp_q.pop_front());
        n_out++;
      end
      hold = m_valid && !m_ready;
      held = m_data;
      if (done_o) done_seen++;
      if (s_valid && s_ready) idx++;
      @(negedge clk);
      cyc++;
      if (abort_at > 0 && idx >= abort_at) break;
    end
    if (abort_at == 0) begin
      check({name, "_done_seen"}, DW'(done_seen), 32'd1);
      check({name, "_count"}, DW'(n_out), DW'(n_exp));
      check({name, "_exp_left"}, DW'(exp_q.size()), 32'd0);
      #1;
      check({name, "_done_pulse"}, DW'(done_o), 32'd0);
      check({name, "_busy_after"}, DW'(busy_o), 32'd0);
      check({name, "_state_after"}, DW'(state_o), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_valid", DW'(m_valid), 32'd0);
    check("rst_s_ready", DW'(s_ready), 32'd0);
    check("rst_busy", DW'(busy_o), 32'd0);
    check("rst_done", DW'(done_o), 32'd0);
    check("rst_sat", DW'(sat_o), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_state", DW'(state_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: identity kernel, ramp image
    set_coefs(32'd1024, 32'd0);
    load_coefs();
    for (int i = 0; i < 64; i++) pix_v[i] = DW'(i) << 10;
    push_identity();
    run_frame("t1", 0, 100, 0, NRES);
    check("t1_sat", DW'(sat_o), 32'd0);

    // 2: box kernel, constant 2.0
    set_coefs(32'd1024, 32'd1024);
    load_coefs();
    fill_pix(32'd2048);
    push_box2048();
    run_frame("t2", 0, 100, 0, NRES);
    check("t2_sat", DW'(sat_o), 32'd0);

    // 3: positive and negative saturation
    fill_pix(32'h7FFF_FFFF);
    push_const(32'h7FFF_FFFF);
    run_frame("t3p", 0, 100, 0, NRES);
    check("t3p_sat", DW'(sat_o), 32'd1);
    fill_pix(32'h8000_0000);
    push_const(32'h8000_0000);
    run_frame("t3n", 0, 100, 0, NRES);
    check("t3n_sat", DW'(sat_o), 32'd1);

    // 4: rounding half up: 0.5 * raw 1 -> 1, 0.5 * raw -1 -> 0
    set_coefs(32'd512, 32'd0);
    load_coefs();
    fill_pix(32'd1);
    push_const(32'd1);
    run_frame("t4p", 0, 100, 0, NRES);
    check("t4p_sat_cleared", DW'(sat_o), 32'd0);
    fill_pix(32'hFFFF_FFFF);
    push_const(32'd0);
    run_frame("t4n", 0, 100, 0, NRES);

    // 5: test 2 with input gaps and output back-pressure
    set_coefs(32'd1024, 32'd1024);
    load_coefs();
    fill_pix(32'd2048);
    push_box2048();
    run_frame("t5", 30, 50, 0, NRES);
    check("t5_sat", DW'(sat_o), 32'd0);

    // 6: reset after 20 accepted pixels, then a full identity frame
    set_coefs(32'd1024, 32'd0);
    load_coefs();
    for (int i = 0; i < 64; i++) pix_v[i] = DW'(i) << 10;
    push_identity();
    run_frame("t6a", 0, 100, 20, NRES);
    rst = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_m_valid", DW'(m_valid), 32'd0);
    check("t6_busy", DW'(busy_o), 32'd0);
    check("t6_done", DW'(done_o), 32'd0);
    check("t6_state", DW'(state_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("t6_no_done", DW'(done_o), 32'd0);
    end
    exp_q.delete();
    load_coefs();
    push_identity();
    run_frame("t6b", 0, 100, 0, NRES);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
